// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU op sequencer: op codes, FSM states,
// ALU control encodings and the captured command record.
package alu_seq_pkg;

  localparam int unsigned CMD_ADDR_W = 5;
  localparam int unsigned CMD_DATA_W = 32;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_ADDI = 2'd1,
    OP_BNE  = 2'd2,
    OP_ILL  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  // "type" is a keyword, so the op code field is named op.
  typedef struct packed {
    op_e                   op;
    logic [CMD_ADDR_W-1:0] rs1;
    logic [CMD_ADDR_W-1:0] rs2;
    logic [CMD_ADDR_W-1:0] rd;
    logic [CMD_DATA_W-1:0] imm;
  } cmd_t;

endpackage

// File: rtl/alu_seq_ctrl_decode.sv
// Combinational map from a captured command to datapath control bits.
module alu_seq_ctrl_decode
  import alu_seq_pkg::*;
(
  input  cmd_t cmd,
  output logic alu_src,
  output logic alu_ctrl,
  output logic we_req,
  output logic is_branch,
  output logic is_ill
);

  always_comb begin
    alu_src   = (cmd.op == OP_ADDI);
    alu_ctrl  = (cmd.op == OP_BNE) ? ALU_SUB : ALU_ADD;
    // Writes to r0 are suppressed so the zero register stays zero.
    we_req    = ((cmd.op == OP_ADD) || (cmd.op == OP_ADDI)) && (cmd.rd != '0);
    is_branch = (cmd.op == OP_BNE);
    is_ill    = (cmd.op == OP_ILL);
  end

  logic unused_fields;
  assign unused_fields = ^{cmd.rs1, cmd.rs2, cmd.imm};

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle IDLE/EXEC/RESP controller driving the register-file/ALU datapath.
// Optional performance counters are enabled by defining PERF_CNT_EN.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = CMD_ADDR_W,
  parameter int unsigned DATA_W = CMD_DATA_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [1:0]        op_type,
  input  logic [ADDR_W-1:0] op_rs1,
  input  logic [ADDR_W-1:0] op_rs2,
  input  logic [ADDR_W-1:0] op_rd,
  input  logic [DATA_W-1:0] op_imm,
  output logic [ADDR_W-1:0] rs1,
  output logic [ADDR_W-1:0] rs2,
  output logic [ADDR_W-1:0] rd,
  output logic              reg_we,
  output logic              alu_src,
  output logic [DATA_W-1:0] imm_op,
  output logic              alu_ctrl,
  input  logic              eq,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_taken,
  output logic              resp_err,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  taken_cnt
);

  state_e           state_q, state_d;
  cmd_t             cmd_q, cmd_d;
  logic             resp_taken_q, resp_taken_d;
  logic             resp_err_q, resp_err_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  cmd_t op_cmd;
  logic accept, retire;
  logic dec_alu_src, dec_alu_ctrl, dec_we_req, dec_is_branch, dec_is_ill;

  assign op_cmd = '{op: op_e'(op_type), rs1: op_rs1, rs2: op_rs2, rd: op_rd, imm: op_imm};

  alu_seq_ctrl_decode u_decode (
    .cmd       (cmd_q),
    .alu_src   (dec_alu_src),
    .alu_ctrl  (dec_alu_ctrl),
    .we_req    (dec_we_req),
    .is_branch (dec_is_branch),
    .is_ill    (dec_is_ill)
  );

  // op_ready follows resp_ready in RESP so a new op can overlap the response hand-off.
  assign op_ready = (state_q == S_IDLE) || ((state_q == S_RESP) && resp_ready);
  assign accept   = op_valid && op_ready;
  assign retire   = (state_q == S_RESP) && resp_ready;

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    resp_taken_d = resp_taken_q;
    resp_err_d   = resp_err_q;
    retire_cnt_d = retire_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cmd_d   = op_cmd;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        resp_taken_d = dec_is_branch && !eq;
        resp_err_d   = dec_is_ill;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (retire) begin
          retire_cnt_d = retire_cnt_q + 1'b1;
          if (accept) begin
            cmd_d   = op_cmd;
            state_d = S_EXEC;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cmd_q        <= '0;
      resp_taken_q <= 1'b0;
      resp_err_q   <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      resp_taken_q <= resp_taken_d;
      resp_err_q   <= resp_err_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // Datapath controls track the command register, so they hold outside EXEC.
  assign rs1        = cmd_q.rs1;
  assign rs2        = cmd_q.rs2;
  assign rd         = cmd_q.rd;
  assign imm_op     = cmd_q.imm;
  assign alu_src    = dec_alu_src;
  assign alu_ctrl   = dec_alu_ctrl;
  assign reg_we     = (state_q == S_EXEC) && dec_we_req;
  assign resp_valid = (state_q == S_RESP);
  assign resp_taken = resp_taken_q;
  assign resp_err   = resp_err_q;
  assign retire_cnt = retire_cnt_q;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    taken_cnt_d = taken_cnt_q;
    if (resp_valid && !resp_ready) stall_cnt_d = stall_cnt_q + 1'b1;
    if (retire && dec_is_branch && resp_taken_q) taken_cnt_d = taken_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      taken_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign taken_cnt = taken_cnt_q;
`else
  logic unused_branch;
  assign unused_branch = dec_is_branch;
  assign stall_cnt     = '0;
  assign taken_cnt     = '0;
`endif

endmodule
